// File: rtl/full_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : full_subtractor
// Description : Parameterisable ripple-borrow full subtractor with registered
//               outputs. Computes {co,s} = a - b - ci. One cycle of latency,
//               and no combinational path from the inputs to the outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module full_subtractor #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             co,
    output logic [WIDTH-1:0] s
);

    // Borrow chain: w_bw[0] is the borrow-in, w_bw[WIDTH] is the borrow-out.
    logic [WIDTH:0]   w_bw;
    logic [WIDTH-1:0] w_d;

    assign w_bw[0] = ci;

    // One full-subtractor cell per bit. The borrow ripples from LSB to MSB.
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            assign w_d[i]    = a[i] ^ b[i] ^ w_bw[i];
            assign w_bw[i+1] = (~a[i] & b[i]) | (~a[i] & w_bw[i]) | (b[i] & w_bw[i]);
        end
    endgenerate

    // Register the difference and borrow-out. Reset clears both outputs and
    // takes priority over whatever is on the inputs at that edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            s  <= '0;
            co <= 1'b0;
        end else begin
            s  <= w_d;
            co <= w_bw[WIDTH];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_full_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_full_subtractor
// Description : Self-checking bench for full_subtractor. Exercises a WIDTH=1
//               instance and a WIDTH=4 instance. Expected results come from
//               plain unsigned arithmetic: {co,s} = a - b - ci.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_full_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       a1, b1, ci1;
    logic       co1, s1;
    logic [3:0] a4, b4;
    logic       ci4;
    logic       co4;
    logic [3:0] s4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    full_subtractor #(.WIDTH(1)) u_dut1 (
        .clk (clk), .rst (rst), .a (a1), .b (b1), .ci (ci1), .co (co1), .s (s1)
    );

    full_subtractor #(.WIDTH(4)) u_dut4 (
        .clk (clk), .rst (rst), .a (a4), .b (b4), .ci (ci4), .co (co4), .s (s4)
    );

    // Reference model: the borrow-out is the bit above the operand width in
    // a plain unsigned subtraction.
    function automatic logic [4:0] ref1(input logic a, input logic b, input logic ci);
        logic [1:0] r;
        r = {1'b0, a} - {1'b0, b} - {1'b0, ci};
        return {3'b000, r};
    endfunction

    function automatic logic [4:0] ref4(input logic [3:0] a, input logic [3:0] b, input logic ci);
        logic [4:0] r;
        r = {1'b0, a} - {1'b0, b} - {4'b0000, ci};
        return r;
    endfunction

    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
        end
    endtask

    // Wait for the next rising edge and sample just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] exp1;
        logic [4:0] exp4;
        logic [2:0] v;

        // Reset held for two edges with all-ones inputs.
        rst = 1'b1;
        a1 = 1'b1; b1 = 1'b1; ci1 = 1'b1;
        a4 = 4'hF; b4 = 4'hF; ci4 = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            check("reset_w1", {3'b000, co1, s1}, 5'b00000);
            check("reset_w4", {co4, s4}, 5'b00000);
        end
        rst = 1'b0;

        // WIDTH=1 exhaustive truth table.
        for (int k = 0; k < 8; k++) begin
            v = 3'(k);
            a1 = v[2]; b1 = v[1]; ci1 = v[0];
            exp1 = ref1(a1, b1, ci1);
            tick();
            check($sformatf("truth_%0d%0d%0d", v[2], v[1], v[0]), {3'b000, co1, s1}, exp1);
        end

        // Back-to-back directed pair.
        a1 = 1'b0; b1 = 1'b1; ci1 = 1'b1;
        tick();
        check("dir_011", {3'b000, co1, s1}, 5'b00010);
        a1 = 1'b1; b1 = 1'b0; ci1 = 1'b0;
        tick();
        check("dir_100", {3'b000, co1, s1}, 5'b00001);

        // Mid-run reset coinciding with new operands.
        a1 = 1'b0; b1 = 1'b1; ci1 = 1'b0;
        rst = 1'b1;
        tick();
        check("midrst_w1", {3'b000, co1, s1}, 5'b00000);
        check("midrst_w4", {co4, s4}, 5'b00000);
        rst = 1'b0;
        tick();
        check("post_rst", {3'b000, co1, s1}, 5'b00011);

        // Unknown inputs propagate, then clear on the next known inputs.
        a1 = 1'bx; b1 = 1'bx; ci1 = 1'bx;
        tick();
        check("x_prop", {3'b000, co1, s1}, {3'b000, 1'bx, 1'bx});
        a1 = 1'b1; b1 = 1'b1; ci1 = 1'b0;
        tick();
        check("x_clear", {3'b000, co1, s1}, 5'b00000);

        // WIDTH=4 directed cases.
        a4 = 4'd3; b4 = 4'd5; ci4 = 1'b1;
        tick();
        check("w4_3m5m1", {co4, s4}, 5'b1_1101);
        a4 = 4'd9; b4 = 4'd4; ci4 = 1'b0;
        tick();
        check("w4_9m4", {co4, s4}, 5'b0_0101);

        // Boundary: equal operands with borrow-in, and max minus zero.
        a4 = 4'd7; b4 = 4'd7; ci4 = 1'b1;
        tick();
        check("w4_eq_ci", {co4, s4}, 5'b1_1111);
        a4 = 4'hF; b4 = 4'h0; ci4 = 1'b0;
        tick();
        check("w4_max", {co4, s4}, 5'b0_1111);

        // Random operands on both instances, one new vector every cycle.
        for (int k = 0; k < 60; k++) begin
            a1  = 1'($urandom);
            b1  = 1'($urandom);
            ci1 = 1'($urandom);
            a4  = 4'($urandom);
            b4  = 4'($urandom);
            ci4 = 1'($urandom);
            exp1 = ref1(a1, b1, ci1);
            exp4 = ref4(a4, b4, ci4);
            tick();
            check("rand_w1", {3'b000, co1, s1}, exp1);
            check("rand_w4", {co4, s4}, exp4);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
